// File: rtl/axis_arb_pkg.sv
// Shared types and the round-robin pick helper for the AXIS arbiter.
package axis_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    // Upper bound on requester count that rr_pick can scan.
    localparam int ARB_MAX_INPUTS = 32;
    localparam int ARB_IDX_W      = 5;

    // First set bit of valid, scanning from pointer upward modulo n.
    // If nothing is set, the result is pointer.
    function automatic int rr_pick(input logic [ARB_MAX_INPUTS-1:0] valid,
                                   input int n, input int pointer);
        int   idx;
        int   pick;
        logic found;
        pick  = pointer;
        found = 1'b0;
        for (int i = 0; i < ARB_MAX_INPUTS; i++) begin
            if (i < n) begin
                idx = pointer + i;
                if (idx >= n) idx = idx - n;
                if (!found && valid[idx[ARB_IDX_W-1:0]]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-stage registered AXIS slice. It accepts a new beat whenever its register
// is empty or is being drained in the same cycle.
module axis_reg_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             src_ready,
    output logic             dst_valid,
    output logic [WIDTH-1:0] dst_data,
    input  logic             dst_ready
);

    assign src_ready = !dst_valid || dst_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            dst_valid <= 1'b0;
            dst_data  <= '0;
        end else if (src_ready) begin
            dst_valid <= src_valid;
            if (src_valid) dst_data <= src_data;
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXIS arbiter: N requesters share one registered output, with a burst limit per grant.
// Define AXIS_RR_ARBITER_LAST_EN to add tlast ports and make grants end on packet boundaries.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int N_INPUTS   = 4,
    parameter int BURST_LEN  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_INPUTS-1:0]            input_valid,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] input_data,
    output logic [N_INPUTS-1:0]            input_ready,
`ifdef AXIS_RR_ARBITER_LAST_EN
    input  logic [N_INPUTS-1:0]            input_last,
    output logic                           output_last,
`endif
    output logic                           output_valid,
    output logic [DATA_WIDTH-1:0]          output_data,
    input  logic                           output_ready,
    output logic [$clog2(N_INPUTS)-1:0]    grant_index
);

    localparam int IW = $clog2(N_INPUTS);
    localparam int CW = $clog2(BURST_LEN + 1);
`ifdef AXIS_RR_ARBITER_LAST_EN
    localparam int SW = DATA_WIDTH + 1;
`else
    localparam int SW = DATA_WIDTH;
`endif

    arb_state_t            state;
    logic [IW-1:0]         pointer;
    logic [CW-1:0]         burst_cnt;
    logic [IW-1:0]         grant_pick;
    logic [IW-1:0]         next_pointer;
    logic                  slot_free;
    logic                  src_valid;
    logic                  accept;
    logic                  release_grant;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [SW-1:0]         slice_data;
    logic [SW-1:0]         slice_q;

    assign grant_pick   = IW'(rr_pick(ARB_MAX_INPUTS'(input_valid), N_INPUTS, int'(pointer)));
    assign next_pointer = (grant_index == IW'(N_INPUTS - 1)) ? '0 : grant_index + 1'b1;

    assign beat_data = input_data[grant_index*DATA_WIDTH +: DATA_WIDTH];
    assign src_valid = (state == ARB_GRANT) && input_valid[grant_index];
    assign accept    = src_valid && slot_free;

    always_comb begin
        input_ready = '0;
        if (state == ARB_GRANT) input_ready[grant_index] = slot_free;
    end

`ifdef AXIS_RR_ARBITER_LAST_EN
    // Packet atomicity: only an accepted last beat ends the grant.
    assign release_grant = accept && input_last[grant_index];
    assign slice_data    = {input_last[grant_index], beat_data};
    assign {output_last, output_data} = slice_q;
`else
    assign release_grant = (accept && burst_cnt == CW'(BURST_LEN - 1)) || !input_valid[grant_index];
    assign slice_data    = beat_data;
    assign output_data   = slice_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ARB_IDLE;
            pointer     <= '0;
            grant_index <= '0;
            burst_cnt   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|input_valid) begin
                        grant_index <= grant_pick;
                        burst_cnt   <= '0;
                        state       <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    // Saturate so long packets never wrap the counter.
                    if (accept && burst_cnt != CW'(BURST_LEN)) burst_cnt <= burst_cnt + 1'b1;
                    if (release_grant) begin
                        state   <= ARB_IDLE;
                        pointer <= next_pointer;
                    end
                end
            endcase
        end
    end

    axis_reg_slice #(
        .WIDTH(SW)
    ) u_out_slice (
        .clk      (clk),
        .rst      (rst),
        .src_valid(src_valid),
        .src_data (slice_data),
        .src_ready(slot_free),
        .dst_valid(output_valid),
        .dst_data (slice_q),
        .dst_ready(output_ready)
    );

endmodule
